// File: rtl/onehot_decoder.sv
// Registered binary-to-one-hot decoder with enable, valid/out-of-range flags
// and optional inverted output polarity. One flop per output line.

module onehot_decoder_lane #(
    parameter int BITS       = 5,
    parameter int IDX        = 0,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [BITS-1:0] code_in,
    output logic            line
);
    localparam logic [BITS-1:0] MATCH = BITS'(IDX);

    logic hit;

    assign hit = en && (code_in == MATCH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) line <= ACTIVE_LOW;
        else     line <= hit ^ ACTIVE_LOW;
    end
endmodule

module onehot_decoder #(
    parameter int BITS       = 5,
    parameter int OUTPUTS    = 2**BITS,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [BITS-1:0]    code_in,
    output logic [OUTPUTS-1:0] code_out,
    output logic               valid,
    output logic               err
);
    // One extra bit so OUTPUTS == 2**BITS is representable; the compare then
    // can never be true and err stays low.
    localparam logic [BITS:0] LIMIT = (BITS+1)'(OUTPUTS);

    logic oor;

    assign oor = ({1'b0, code_in} >= LIMIT);

    // Out-of-range codes match no lane index, so lines go inactive on their own.
    for (genvar i = 0; i < OUTPUTS; i++) begin : g_lane
        onehot_decoder_lane #(
            .BITS       (BITS),
            .IDX        (i),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .code_in (code_in),
            .line    (code_out[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            valid <= en;
            err   <= en && oor;
        end
    end
endmodule

// File: tb/tb_onehot_decoder.sv
// Directed bench for onehot_decoder: default, range-limited and active-low builds.

module tb_onehot_decoder;
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [4:0]  code_a;
    logic [4:0]  code_b;
    logic [2:0]  code_c;
    logic [31:0] out_a;
    logic [19:0] out_b;
    logic [7:0]  out_c;
    logic        valid_a, err_a, valid_b, err_b, valid_c, err_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    onehot_decoder #(.BITS(5)) u_a (
        .clk(clk), .rst(rst), .en(en), .code_in(code_a),
        .code_out(out_a), .valid(valid_a), .err(err_a));

    onehot_decoder #(.BITS(5), .OUTPUTS(20)) u_b (
        .clk(clk), .rst(rst), .en(en), .code_in(code_b),
        .code_out(out_b), .valid(valid_b), .err(err_b));

    onehot_decoder #(.BITS(3), .ACTIVE_LOW(1'b1)) u_c (
        .clk(clk), .rst(rst), .en(en), .code_in(code_c),
        .code_out(out_c), .valid(valid_c), .err(err_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; code_a = 5'd3; code_b = 5'd3; code_c = 3'd3;
        tick();
        tick();
        checks++;
        if (out_a !== 32'h0 || valid_a !== 1'b0 || err_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_a: out=%h v=%b e=%b want 00000000 0 0", out_a, valid_a, err_a);
        end
        checks++;
        if (out_b !== 20'h0 || valid_b !== 1'b0 || err_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_b: out=%h v=%b e=%b want 00000 0 0", out_b, valid_b, err_b);
        end
        checks++;
        if (out_c !== 8'hFF || valid_c !== 1'b0 || err_c !== 1'b0) begin
            failures++;
            $display("FAIL reset_c: out=%h v=%b e=%b want ff 0 0", out_c, valid_c, err_c);
        end
        rst = 1'b0;
    endtask

    task automatic test_sweep();
        logic [31:0] exp;
        for (int i = 0; i < 32; i++) begin
            en = 1'b1; code_a = 5'(i);
            tick();
            exp = 32'h1 << i;
            checks++;
            if (out_a !== exp || valid_a !== 1'b1 || err_a !== 1'b0) begin
                failures++;
                $display("FAIL sweep[%0d]: out=%h v=%b e=%b want %h 1 0", i, out_a, valid_a, err_a, exp);
            end
        end
    endtask

    task automatic test_wrap();
        logic [4:0]  codes [4] = '{5'd30, 5'd31, 5'd0, 5'd1};
        logic [31:0] exps  [4] = '{32'h4000_0000, 32'h8000_0000, 32'h0000_0001, 32'h0000_0002};
        for (int i = 0; i < 4; i++) begin
            en = 1'b1; code_a = codes[i];
            tick();
            checks++;
            if (out_a !== exps[i] || valid_a !== 1'b1) begin
                failures++;
                $display("FAIL wrap[%0d]: out=%h v=%b want %h 1", i, out_a, valid_a, exps[i]);
            end
        end
    endtask

    task automatic test_enable();
        logic        ens  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] exps [4] = '{32'h80, 32'h0, 32'h0, 32'h80};
        for (int i = 0; i < 4; i++) begin
            en = ens[i]; code_a = 5'd7;
            tick();
            checks++;
            if (out_a !== exps[i] || valid_a !== ens[i] || err_a !== 1'b0) begin
                failures++;
                $display("FAIL enable[%0d]: out=%h v=%b e=%b want %h %b 0", i, out_a, valid_a, err_a, exps[i], ens[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        en = 1'b1; code_a = 5'd16; code_c = 3'd5;
        tick();
        checks++;
        if (out_a !== 32'h0001_0000 || valid_a !== 1'b1) begin
            failures++;
            $display("FAIL areset_pre: out=%h v=%b want 00010000 1", out_a, valid_a);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_a !== 32'h0 || valid_a !== 1'b0 || out_c !== 8'hFF) begin
            failures++;
            $display("FAIL areset_now: out_a=%h v=%b out_c=%h want 00000000 0 ff", out_a, valid_a, out_c);
        end
        #2 rst = 1'b0;
        tick();
        checks++;
        if (out_a !== 32'h0001_0000 || valid_a !== 1'b1 || out_c !== 8'hDF) begin
            failures++;
            $display("FAIL areset_resume: out_a=%h v=%b out_c=%h want 00010000 1 df", out_a, valid_a, out_c);
        end
    endtask

    task automatic test_range();
        logic [4:0]  codes [3] = '{5'd19, 5'd20, 5'd31};
        logic [19:0] exps  [3] = '{20'h8_0000, 20'h0, 20'h0};
        logic        errs  [3] = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            en = 1'b1; code_b = codes[i]; code_a = codes[i];
            tick();
            checks++;
            if (out_b !== exps[i] || valid_b !== 1'b1 || err_b !== errs[i]) begin
                failures++;
                $display("FAIL range[%0d]: out=%h v=%b e=%b want %h 1 %b", i, out_b, valid_b, err_b, exps[i], errs[i]);
            end
        end
        checks++;
        if (err_a !== 1'b0 || out_a !== 32'h8000_0000) begin
            failures++;
            $display("FAIL range_full: out=%h e=%b want 80000000 0", out_a, err_a);
        end
        en = 1'b0;
        tick();
        checks++;
        if (err_b !== 1'b0 || valid_b !== 1'b0 || out_b !== 20'h0) begin
            failures++;
            $display("FAIL range_idle: out=%h v=%b e=%b want 00000 0 0", out_b, valid_b, err_b);
        end
    endtask

    task automatic test_active_low();
        en = 1'b1; code_c = 3'd2;
        tick();
        checks++;
        if (out_c !== 8'hFB || valid_c !== 1'b1 || err_c !== 1'b0) begin
            failures++;
            $display("FAIL alow_hit: out=%h v=%b e=%b want fb 1 0", out_c, valid_c, err_c);
        end
        code_c = 3'd7;
        tick();
        checks++;
        if (out_c !== 8'h7F || valid_c !== 1'b1) begin
            failures++;
            $display("FAIL alow_msb: out=%h v=%b want 7f 1", out_c, valid_c);
        end
        en = 1'b0;
        tick();
        checks++;
        if (out_c !== 8'hFF || valid_c !== 1'b0) begin
            failures++;
            $display("FAIL alow_idle: out=%h v=%b want ff 0", out_c, valid_c);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; code_a = '0; code_b = '0; code_c = '0;
        test_reset();
        test_sweep();
        test_wrap();
        test_enable();
        test_async_reset();
        test_range();
        test_active_low();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/onehot_decoder.md
Name: onehot_decoder

Overview:
Registered binary-to-one-hot decoder. It converts a BITS-wide binary code into a one-hot select vector, one line per code. It is used as a select/enable generator, e.g. address, register-bank or channel select, driven by a counter or control FSM. It has a 1-cycle registered output with enable, a valid flag, an out-of-range flag and an optional active-low output polarity.

Parameters:
BITS, 5, width of the binary input code; legal range 1..8.
OUTPUTS, 2**BITS, number of decoded output lines; legal range 1..2**BITS.
ACTIVE_LOW, 0, 0 = asserted line is 1 and others 0; 1 = whole output vector inverted.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous reset, active-high.
en  input  1  decode enable, sampled on the rising edge of clk.
code_in  input  BITS  binary code to decode, sampled on the rising edge of clk.
code_out  output  OUTPUTS  registered one-hot (or one-cold) select vector.
valid  output  1  registered; high for one cycle per cycle in which en was sampled high.
err  output  1  registered; high when an enabled code had code_in >= OUTPUTS.

Behaviour:
- Reset (rst high, asynchronous, immediate, independent of clk):
  - code_out = all-inactive: all 0 if ACTIVE_LOW=0, all 1 if ACTIVE_LOW=1.
  - valid = 0, err = 0.
  - Reset held: outputs stay at reset values regardless of en or code_in.
  - Reset deasserts: first update occurs at the next rising edge.
- Rising edge, en=1, code_in < OUTPUTS:
  - Active bit = bit code_in of code_out; all other bits inactive.
  - valid <= 1, err <= 0.
- Rising edge, en=1, code_in >= OUTPUTS (possible only when OUTPUTS < 2**BITS):
  - code_out <= all-inactive.
  - valid <= 1, err <= 1.
- Rising edge, en=0:
  - code_out <= all-inactive, valid <= 0, err <= 0. The previous value is not held.
- Latency: exactly 1 clock from sampled code_in/en to code_out/valid/err. No combinational path from inputs to outputs.
- Throughput: a new code is accepted every cycle; no handshake or backpressure.
- Output invariant: code_out has at most one active bit, exactly one when valid=1 and err=0.
- Polarity: ACTIVE_LOW inverts code_out only; valid and err are always active-high.
- Wrap-around: consecutive codes 2**BITS-1 then 0 move the active bit from the MSB to bit 0 on successive cycles with no gap or glitch cycle.
- Reset mid-stream: outputs go to reset values immediately. Decoding resumes from the first enabled edge after rst falls.
- Unknown inputs: X/Z on code_in with en=1 is a stimulus error. No output requirement applies; simulation need not trap it.

Test Plan:
1. Full sweep, BITS=5 defaults: en=1, code_in increments 0..31 one per clock -> one cycle later code_out = 32'h1 << code_in, valid=1, err=0 every cycle; code 31 gives 32'h8000_0000.
2. Wrap: code_in sequence 30, 31, 0, 1 -> code_out 32'h4000_0000, 32'h8000_0000, 32'h0000_0001, 32'h0000_0002 on consecutive cycles.
3. Enable gating: code_in=7 with en=1, then en=0 for 2 cycles, then en=1 -> code_out 32'h80 with valid=1, then 32'h0 with valid=0 for 2 cycles, then 32'h80 with valid=1.
4. Async reset mid-stream: rst pulsed high between clock edges while code_out=32'h0001_0000 -> code_out=0 and valid=0 immediately before the next edge; resumes one edge after rst falls.
5. Range check, BITS=5, OUTPUTS=20: code_in=19 -> bit 19 set, err=0; code_in=20 and code_in=31 -> code_out=0, valid=1, err=1.
6. ACTIVE_LOW=1, BITS=3: reset -> code_out=8'hFF; code_in=2, en=1 -> code_out=8'hFB, valid=1.
